coin_accumulator: RTL and testbench
===================================

# coin_accumulator

Upstream front end of the vending path. It accepts coin events, accumulates them into one credit value, and offers that credit to the vending FSM's `money_in` port with a valid/ready handshake. It also rejects coins that would overflow the credit width, and returns the full credit as a one-cycle refund when the customer cancels. The vending FSM only ever sees a stable, range-checked amount.

## Interface
- `CW`, default 4: credit width. Matches the vending FSM's `money_in`.
- `MAX_CREDIT`, default 15: maximum accepted credit. Must be ≤ 2^CW−1.
- `TIMEOUT`, default 8: idle cycles in ACCUM before the credit is offered automatically. Must be ≥ 2.

Ports:
- `clk` in 1: the single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `coin_valid` in 1: one-cycle coin-inserted strobe.
- `coin_type` in 2: coin denomination, 00=1, 01=2, 10=5, 11=10 units.
- `done_btn` in 1: customer has finished inserting coins.
- `cancel` in 1: customer requests a refund.
- `credit_ready` in 1: downstream accepts the offered credit.
- `credit` out CW: accumulated credit.
- `credit_valid` out 1: credit is offered and stable.
- `coin_reject` out 1: one-cycle pulse, last coin refused.
- `refund` out CW: amount being refunded.
- `refund_valid` out 1: one-cycle refund strobe.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Four states: IDLE, ACCUM, OFFER, REFUND.
- **IDLE**: `credit`=0.
  - `coin_valid` adds the coin value and moves to ACCUM.
  - `done_btn` and `cancel` are ignored.
- **ACCUM**:
  - Every accepted coin adds its value and clears the idle timer.
  - `done_btn`, or the timer reaching TIMEOUT−1, moves to OFFER.
  - `cancel` moves to REFUND. `cancel` beats `done_btn` and the timeout.
- **OFFER**:
  - `credit_valid`=1 and `credit` is frozen.
  - `credit_ready` moves to IDLE and clears `credit`.
  - `cancel` without `credit_ready` moves to REFUND.
  - `credit_ready` and `cancel` in the same cycle: `credit_ready` wins.
  - Any `coin_valid` in OFFER or REFUND is rejected.
- **REFUND**: `refund_valid`=1 for exactly one cycle, with `refund`=`credit`. Then moves to IDLE with `credit` cleared.
- **Overflow**: the sum is computed at CW+1 bits. If `credit` + value > MAX_CREDIT, the coin is rejected and `credit` is unchanged.
- **Simultaneous events in ACCUM**:
  - `coin_valid` with `done_btn`: the coin is added, and OFFER presents the updated sum.
  - `coin_valid` with `cancel`: the coin is added and included in the refund.
  - A rejected coin does not clear the idle timer.
- **Reset mid-operation**: credit is discarded with no refund pulse, and the FSM returns to IDLE.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- Coin sampled at edge N:
  - `credit` shows the new sum in cycle N+1.
  - `coin_reject`, if the coin is refused, is high in cycle N+1 only.
- `done_btn` sampled at edge N: `credit_valid` is high from cycle N+1.
- Handshake:
  - A transfer completes on an edge where `credit_valid` && `credit_ready`.
  - `credit_valid` and `credit` drop in the next cycle.
  - Minimum latency from the last coin to `credit_valid` is 1 cycle.
- Timeout: with no accepted coin after edge N, `credit_valid` rises in cycle N+TIMEOUT.
- `cancel` sampled at edge N: `refund_valid` is high in cycle N+1 only, and `busy` is low from cycle N+2.
- `credit_ready` outside OFFER has no effect.

## Structure
- Shared package `vend_pkg` holds:
  - coin value constants (1, 2, 5, 10);
  - the 2-bit state encoding;
  - the coin-type decode function, which the vending FSM reuses for its price logic.
- One sub-module, `idle_timer`: a clearable saturating counter with an enable, and a `expired` output asserted at TIMEOUT−1. It is parameterised by TIMEOUT.
- Everything else lives in the top-level FSM.

## Test plan
- **Accumulate and offer.** Coins 5, 2, 1 on consecutive cycles, then `done_btn` → `credit`=8, `credit_valid`=1 on the cycle after `done_btn`. `credit_ready`=1 → back to IDLE with `credit`=0 the next cycle.
- **Overflow reject.** Coins 10, 5 (credit 15), then a 1 → `coin_reject` pulses one cycle, `credit` stays 15. `done_btn` then offers 15.
- **Timeout.** A single 2 coin, no further input → `credit_valid` rises exactly TIMEOUT (8) cycles after the coin edge, with `credit`=2.
- **Cancel.**
  - Coins 10, 2 then `cancel` → `refund_valid` one cycle with `refund`=12, `credit_valid` never asserted.
  - Cancel together with a 1 coin → `refund`=13.
- **Handshake collisions.**
  - In OFFER with `credit_ready`=0 for 5 cycles, `credit` stays stable and a coin is rejected.
  - `credit_ready` and `cancel` in the same cycle → transfer completes, no refund.
- **Asynchronous reset.** Assert `rst` mid-ACCUM (credit 7) between clock edges → all outputs 0 immediately, no `refund_valid`, state IDLE after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared vending-path definitions: coin values, FSM state encoding and the
// coin-type decode reused by the vending FSM for its price logic.
package vend_pkg;

  localparam logic [3:0] COIN_VAL_1  = 4'd1;
  localparam logic [3:0] COIN_VAL_2  = 4'd2;
  localparam logic [3:0] COIN_VAL_5  = 4'd5;
  localparam logic [3:0] COIN_VAL_10 = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCUM  = 2'b01,
    ST_OFFER  = 2'b10,
    ST_REFUND = 2'b11
  } state_e;

  function automatic logic [3:0] coin_value(input logic [1:0] coin_type);
    logic [3:0] val;
    case (coin_type)
      2'b00:   val = COIN_VAL_1;
      2'b01:   val = COIN_VAL_2;
      2'b10:   val = COIN_VAL_5;
      default: val = COIN_VAL_10;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/coin_accumulator_idle_timer.sv
// Clearable saturating idle counter; expired is high once TIMEOUT-1 idle
// cycles have been counted since the last clear.
module idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == LAST);

endmodule

// File: rtl/coin_accumulator.sv
// Coin accumulator: sums coin events into a range-checked credit, offers it
// downstream with valid/ready, and refunds the full credit on cancel.
module coin_accumulator
  import vend_pkg::*;
#(
  parameter int CW         = 4,
  parameter int MAX_CREDIT = 15,
  parameter int TIMEOUT    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          coin_valid,
  input  logic [1:0]    coin_type,
  input  logic          done_btn,
  input  logic          cancel,
  input  logic          credit_ready,
  output logic [CW-1:0] credit,
  output logic          credit_valid,
  output logic          coin_reject,
  output logic [CW-1:0] refund,
  output logic          refund_valid,
  output logic          busy
);

  localparam logic [CW:0] MAX_SUM = (CW + 1)'(MAX_CREDIT);

  state_e        state_q, state_d;
  logic [CW-1:0] credit_q, credit_d;
  logic          credit_valid_q, credit_valid_d;
  logic          coin_reject_q, coin_reject_d;
  logic [CW-1:0] refund_q, refund_d;
  logic          refund_valid_q, refund_valid_d;
  logic          busy_q, busy_d;

  logic [CW:0]   sum;
  logic          coin_ok;
  logic          coin_accept;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_expired;

  // Sum is one bit wider than credit so an overflowing coin is caught, not wrapped.
  assign sum     = {1'b0, credit_q} + (CW + 1)'(coin_value(coin_type));
  assign coin_ok = (sum <= MAX_SUM);
  assign coin_accept = coin_valid && coin_ok &&
                       ((state_q == ST_IDLE) || (state_q == ST_ACCUM));

  // A refused coin must not restart the idle window.
  assign timer_clr = (state_q != ST_ACCUM) || coin_accept;
  assign timer_en  = (state_q == ST_ACCUM);

  idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    coin_reject_d  = coin_valid && !coin_accept;
    refund_d       = '0;
    refund_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        credit_d = '0;
        if (coin_accept) begin
          credit_d = sum[CW-1:0];
          state_d  = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (coin_accept) begin
          credit_d = sum[CW-1:0];
        end
        // The refund and the offer both carry the coin taken on this same edge.
        if (cancel) begin
          state_d        = ST_REFUND;
          refund_valid_d = 1'b1;
          refund_d       = credit_d;
        end else if (done_btn || (timer_expired && !coin_accept)) begin
          state_d = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (credit_ready) begin
          state_d  = ST_IDLE;
          credit_d = '0;
        end else if (cancel) begin
          state_d        = ST_REFUND;
          refund_valid_d = 1'b1;
          refund_d       = credit_q;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        credit_d = '0;
      end
    endcase

    credit_valid_d = (state_d == ST_OFFER);
    busy_d         = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      credit_valid_q <= 1'b0;
      coin_reject_q  <= 1'b0;
      refund_q       <= '0;
      refund_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      credit_valid_q <= credit_valid_d;
      coin_reject_q  <= coin_reject_d;
      refund_q       <= refund_d;
      refund_valid_q <= refund_valid_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign credit_valid = credit_valid_q;
  assign coin_reject  = coin_reject_q;
  assign refund       = refund_q;
  assign refund_valid = refund_valid_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_coin_accumulator.sv
// Self-checking bench for coin_accumulator: directed scenarios plus random
// traffic, all compared against a transaction-level credit model.
module tb_coin_accumulator;

  localparam int CW         = 4;
  localparam int MAX_CREDIT = 15;
  localparam int TIMEOUT    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin_type = 2'b00;
  logic          done_btn = 1'b0;
  logic          cancel = 1'b0;
  logic          credit_ready = 1'b0;
  logic [CW-1:0] credit;
  logic          credit_valid;
  logic          coin_reject;
  logic [CW-1:0] refund;
  logic          refund_valid;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Model: phase 0 idle, 1 collecting, 2 offering, 3 refunding.
  int m_phase  = 0;
  int m_credit = 0;
  int m_quiet  = 0;
  int e_refund = 0;
  bit e_reject = 1'b0;
  bit e_rvld   = 1'b0;
  int coin_vals[4] = '{1, 2, 5, 10};

  coin_accumulator #(
    .CW         (CW),
    .MAX_CREDIT (MAX_CREDIT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .coin_valid   (coin_valid),
    .coin_type    (coin_type),
    .done_btn     (done_btn),
    .cancel       (cancel),
    .credit_ready (credit_ready),
    .credit       (credit),
    .credit_valid (credit_valid),
    .coin_reject  (coin_reject),
    .refund       (refund),
    .refund_valid (refund_valid),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] obs_vec();
    return {credit, credit_valid, coin_reject, refund, refund_valid, busy};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [3:0] c;
    logic [3:0] r;
    c = 4'(m_credit);
    r = 4'(e_refund);
    return {c, (m_phase == 2), e_reject, r, e_rvld, (m_phase != 0)};
  endfunction

  task automatic model_reset();
    m_phase  = 0;
    m_credit = 0;
    m_quiet  = 0;
    e_refund = 0;
    e_reject = 1'b0;
    e_rvld   = 1'b0;
  endtask

  task automatic model_step();
    int  v;
    int  q_before;
    bit  acc;
    v        = coin_vals[coin_type];
    acc      = coin_valid && (m_phase <= 1) && (m_credit + v <= MAX_CREDIT);
    e_reject = coin_valid && !acc;
    e_rvld   = 1'b0;
    e_refund = 0;
    q_before = m_quiet;
    case (m_phase)
      0: if (acc) begin
           m_credit = m_credit + v;
           m_phase  = 1;
           m_quiet  = 0;
         end
      1: begin
           if (acc) begin
             m_credit = m_credit + v;
             m_quiet  = 0;
           end else begin
             m_quiet = m_quiet + 1;
           end
           if (cancel) begin
             e_rvld   = 1'b1;
             e_refund = m_credit;
             m_phase  = 3;
           end else if (done_btn || (!acc && q_before == TIMEOUT - 1)) begin
             m_phase = 2;
           end
         end
      2: if (credit_ready) begin
           m_phase  = 0;
           m_credit = 0;
         end else if (cancel) begin
           e_rvld   = 1'b1;
           e_refund = m_credit;
           m_phase  = 3;
         end
      default: begin
        m_phase  = 0;
        m_credit = 0;
      end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    coin_valid   = 1'b0;
    coin_type    = 2'b00;
    done_btn     = 1'b0;
    cancel       = 1'b0;
    credit_ready = 1'b0;
  endtask

  task automatic drop_coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if (obs_vec() !== 12'h000) begin
      errors++;
      $display("FAIL reset_async: outputs=%h want=000", obs_vec());
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs_vec() !== 12'h000) begin
      errors++;
      $display("FAIL reset_held: outputs=%h want=000", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tick();
    checks++;
    if (obs_vec() !== 12'h000) begin
      errors++;
      $display("FAIL reset_release: outputs=%h want=000", obs_vec());
    end
  endtask

  task automatic test_accumulate();
    int want[3] = '{5, 7, 8};
    logic [1:0] types[3] = '{2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 3; i++) begin
      drop_coin(types[i]);
      checks++;
      if (credit !== 4'(want[i]) || busy !== 1'b1 || credit_valid !== 1'b0) begin
        errors++;
        $display("FAIL accum_coin%0d: credit=%0d busy=%b valid=%b want credit=%0d busy=1 valid=0",
                 i, credit, busy, credit_valid, want[i]);
      end
    end
    done_btn = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (credit_valid !== 1'b1 || credit !== 4'd8) begin
      errors++;
      $display("FAIL accum_offer: valid=%b credit=%0d want valid=1 credit=8", credit_valid, credit);
    end
    credit_ready = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (credit_valid !== 1'b0 || credit !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL accum_xfer: valid=%b credit=%0d busy=%b want 0/0/0", credit_valid, credit, busy);
    end
  endtask

  task automatic test_overflow();
    drop_coin(2'b11);
    drop_coin(2'b10);
    drop_coin(2'b00);
    checks++;
    if (coin_reject !== 1'b1 || credit !== 4'd15) begin
      errors++;
      $display("FAIL ovf_reject: reject=%b credit=%0d want reject=1 credit=15", coin_reject, credit);
    end
    tick();
    checks++;
    if (coin_reject !== 1'b0 || credit !== 4'd15) begin
      errors++;
      $display("FAIL ovf_pulse: reject=%b credit=%0d want reject=0 credit=15", coin_reject, credit);
    end
    done_btn = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (credit_valid !== 1'b1 || credit !== 4'd15) begin
      errors++;
      $display("FAIL ovf_offer: valid=%b credit=%0d want valid=1 credit=15", credit_valid, credit);
    end
    credit_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_timeout();
    drop_coin(2'b01);
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      checks++;
      if (credit_valid !== (k == TIMEOUT) || credit !== 4'd2) begin
        errors++;
        $display("FAIL timeout_cycle%0d: valid=%b credit=%0d want valid=%0d credit=2",
                 k, credit_valid, credit, (k == TIMEOUT));
      end
    end
    credit_ready = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_cancel();
    int want[2] = '{12, 13};
    for (int pass = 0; pass < 2; pass++) begin
      drop_coin(2'b11);
      drop_coin(2'b01);
      cancel = 1'b1;
      if (pass == 1) begin
        coin_valid = 1'b1;
        coin_type  = 2'b00;
      end
      tick();
      idle_inputs();
      checks++;
      if (refund_valid !== 1'b1 || refund !== 4'(want[pass]) || credit_valid !== 1'b0) begin
        errors++;
        $display("FAIL cancel%0d_refund: rvld=%b refund=%0d valid=%b want 1/%0d/0",
                 pass, refund_valid, refund, credit_valid, want[pass]);
      end
      tick();
      checks++;
      if (refund_valid !== 1'b0 || busy !== 1'b0 || credit_valid !== 1'b0 || credit !== 4'd0) begin
        errors++;
        $display("FAIL cancel%0d_after: rvld=%b busy=%b valid=%b credit=%0d want 0/0/0/0",
                 pass, refund_valid, busy, credit_valid, credit);
      end
    end
  endtask

  task automatic test_handshake();
    drop_coin(2'b10);
    done_btn = 1'b1;
    tick();
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      coin_valid = (k == 2);
      coin_type  = 2'b00;
      tick();
      idle_inputs();
      checks++;
      if (credit_valid !== 1'b1 || credit !== 4'd5 || coin_reject !== (k == 2)) begin
        errors++;
        $display("FAIL hold%0d: valid=%b credit=%0d reject=%b want 1/5/%0d",
                 k, credit_valid, credit, coin_reject, (k == 2));
      end
    end
    credit_ready = 1'b1;
    cancel       = 1'b1;
    tick();
    idle_inputs();
    checks++;
    if (credit_valid !== 1'b0 || refund_valid !== 1'b0 || busy !== 1'b0 || credit !== 4'd0) begin
      errors++;
      $display("FAIL ready_cancel: valid=%b rvld=%b busy=%b credit=%0d want 0/0/0/0",
               credit_valid, refund_valid, busy, credit);
    end
  endtask

  task automatic test_async_reset();
    drop_coin(2'b10);
    drop_coin(2'b01);
    checks++;
    if (credit !== 4'd7) begin
      errors++;
      $display("FAIL areset_pre: credit=%0d want 7", credit);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (obs_vec() !== 12'h000) begin
      errors++;
      $display("FAIL areset_now: outputs=%h want=000", obs_vec());
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (obs_vec() !== 12'h000) begin
        errors++;
        $display("FAIL areset_after%0d: outputs=%h want=000", k, obs_vec());
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      coin_valid   = ($urandom_range(0, 2) == 0);
      coin_type    = 2'($urandom_range(0, 3));
      done_btn     = ($urandom_range(0, 11) == 0);
      cancel       = ($urandom_range(0, 19) == 0);
      credit_ready = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random_cycle%0d: got {credit,valid,rej,refund,rvld,busy}=%h want=%h",
                 n, obs_vec(), exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_accumulate();
    test_overflow();
    test_timeout();
    test_cancel();
    test_handshake();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
